// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds the FSM state encoding, grant owner codes and default limits.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam logic [1:0] OWN_NONE  = 2'b00;
   localparam logic [1:0] OWN_FETCH = 2'b01;
   localparam logic [1:0] OWN_DATA  = 2'b10;

   localparam int DEF_STARVE_MAX = 3;
   localparam int DEF_TIMEOUT    = 15;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive fetch losses to data; once the count saturates,
// fetch is forced to win the next contended arbitration.
module mem_arb_starve_ctr
   import mips_mem_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic grant_fetch,
   input  logic grant_data,
   output logic force_fetch
);

   localparam int CNT_W = $clog2(STARVE_MAX + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;

   // A loss only counts when fetch was actually asking for the bus.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant_fetch) begin
         starve_cnt <= '0;
      end else if (grant_data && i_req && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   assign force_fetch = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory, with
// data priority, fetch starvation protection and a sticky ack timeout.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic [1:0]        owner,
   output logic              bus_err
);

   localparam int WCNT_W = $clog2(TIMEOUT + 2);
   localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(TIMEOUT);

   arb_state_t        state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
   logic              grant_fetch, grant_data, force_fetch;

   mem_arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (i_req),
      .grant_fetch(grant_fetch),
      .grant_data (grant_data),
      .force_fetch(force_fetch)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_NONE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   // Requests are only looked at in IDLE; a stray ack elsewhere falls through.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = err_q;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_req && (!d_req || force_fetch)) begin
               grant_fetch = 1'b1;
            end else if (d_req) begin
               grant_data = 1'b1;
            end
            if (grant_fetch) begin
               owner_d    = OWN_FETCH;
               addr_d     = i_addr;
               we_d       = 1'b0;
               wdata_d    = '0;
               wait_cnt_d = '0;
               state_d    = ST_ISSUE;
            end else if (grant_data) begin
               owner_d    = OWN_DATA;
               addr_d     = d_addr;
               we_d       = d_we;
               wdata_d    = d_wdata;
               wait_cnt_d = '0;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = ST_RESP;
            end else begin
               wait_cnt_d = WCNT_W'(1);
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = ST_RESP;
            end else if (wait_cnt_q == WCNT_LIMIT) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
         end
         ST_RESP: begin
            owner_d    = OWN_NONE;
            wait_cnt_d = '0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   assign mem_en    = (state_q == ST_ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign i_ready = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
   assign d_ready = (state_q == ST_RESP) && (owner_q == OWN_DATA);
   assign i_rdata = i_ready ? rdata_q : '0;
   assign d_rdata = (d_ready && !we_q) ? rdata_q : '0;

   assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);
   assign owner   = owner_q;
   assign bus_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-age model checks every
// cycle while directed scenarios pin the model with hand-computed values.
module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 3;
   localparam int TIMEOUT    = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        stall;
   logic [1:0]  owner;
   logic        bus_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic checkEnable = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .owner(owner), .bus_err(bus_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s @cycle %0d: got %h, want %h", name, cyc, actual, expected);
      end
   endtask

   // Memory responder: acks ackDelay cycles after mem_en (-1 = never).
   logic [31:0] memArr [0:15];
   int          ackDelay = 0;
   int          respCnt = -1;
   logic        injectAck = 1'b0;
   logic [31:0] pendAddr = '0;
   logic [31:0] pendWdata = '0;
   logic        pendWe = 1'b0;

   always @(posedge clk) begin
      #1;
      if (mem_en) begin
         respCnt   = 0;
         pendAddr  = mem_addr;
         pendWe    = mem_we;
         pendWdata = mem_wdata;
      end else if (respCnt >= 0) begin
         respCnt++;
      end
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (ackDelay >= 0 && respCnt == ackDelay) begin
         mem_ack   = 1'b1;
         mem_rdata = pendWe ? 32'h0 : memArr[pendAddr[5:2]];
         if (pendWe) memArr[pendAddr[5:2]] = pendWdata;
         respCnt = -1;
      end
      if (injectAck) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hDEADBEEF;
      end
   end

   // Reference model: one outstanding transaction tracked by its age in cycles.
   logic        mBusy = 1'b0;
   logic        mFetch = 1'b0;
   logic        mWe = 1'b0;
   logic        mErr = 1'b0;
   logic [31:0] mAddr = '0;
   logic [31:0] mWdata = '0;
   logic [31:0] mData = '0;
   int          mAge = 0;
   int          mRespAge = 0;
   int          mStarve = 0;
   byte         modelGrants[$];
   byte         dutGrants[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         mBusy = 1'b0; mErr = 1'b0; mStarve = 0; mAge = 0; mRespAge = 0;
         mData = '0; mAddr = '0; mWe = 1'b0; mWdata = '0; mFetch = 1'b0;
      end else if (!mBusy) begin
         if (i_req || d_req) begin
            mFetch = i_req && (!d_req || mStarve == STARVE_MAX);
            if (mFetch) mStarve = 0;
            else if (i_req && mStarve < STARVE_MAX) mStarve++;
            mBusy    = 1'b1;
            mAddr    = mFetch ? i_addr : d_addr;
            mWe      = mFetch ? 1'b0 : d_we;
            mWdata   = mFetch ? 32'h0 : d_wdata;
            mAge     = 1;
            mRespAge = 0;
            mData    = '0;
            modelGrants.push_back(mFetch ? "F" : "D");
         end
      end else begin
         if (mRespAge != 0 && mAge == mRespAge) begin
            mBusy = 1'b0;
         end else if (mRespAge == 0) begin
            if (mem_ack) begin
               mData    = mem_rdata;
               mRespAge = mAge + 1;
            end else if (mAge == TIMEOUT + 1) begin
               mErr     = 1'b1;
               mData    = '0;
               mRespAge = mAge + 1;
            end
         end
         mAge++;
      end
   end

   logic cRespNow, cEn, cIRdy, cDRdy;
   int   enCount = 0;

   always @(negedge clk) begin
      if (checkEnable) begin
         cRespNow = mBusy && mRespAge != 0 && mAge == mRespAge;
         cEn      = mBusy && mAge == 1;
         cIRdy    = cRespNow && mFetch;
         cDRdy    = cRespNow && !mFetch;
         checkOutput("cmp_mem_en", mem_en, cEn);
         checkOutput("cmp_mem_we", mem_we, cEn && mWe);
         checkOutput("cmp_i_ready", i_ready, cIRdy);
         checkOutput("cmp_d_ready", d_ready, cDRdy);
         checkOutput("cmp_i_rdata", i_rdata, cIRdy ? mData : 32'h0);
         checkOutput("cmp_d_rdata", d_rdata, (cDRdy && !mWe) ? mData : 32'h0);
         checkOutput("cmp_owner", owner, mBusy ? (mFetch ? 2'b01 : 2'b10) : 2'b00);
         checkOutput("cmp_bus_err", bus_err, mErr);
         checkOutput("cmp_stall", stall, (i_req & ~cIRdy) | (d_req & ~cDRdy));
         if (mBusy) checkOutput("cmp_mem_addr", mem_addr, mAddr);
         if (mBusy && mWe) checkOutput("cmp_mem_wdata", mem_wdata, mWdata);
         if (mem_en) begin
            enCount++;
            dutGrants.push_back(owner == 2'b01 ? "F" : "D");
         end
      end
   end

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwe,
                                input logic [31:0] daddr, input logic [31:0] dwdata);
      @(posedge clk);
      #2;
      i_req = ireq; i_addr = iaddr;
      d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
   endtask

   task automatic waitReady(input string name, input int maxN, output int n);
      logic seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < maxN) begin
         @(negedge clk);
         n++;
         if (i_ready || d_ready) seen = 1'b1;
      end
      checkOutput(name, seen, 1'b1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int    n;
      int    enBase;
      int    nReady;
      logic  early;
      string gs;

      for (int i = 0; i < 16; i++) memArr[i] = {16'hC0DE, 16'(i)};
      memArr[0] = 32'h8C010000;
      memArr[1] = 32'h200A0005;
      memArr[4] = 32'h11110010;
      memArr[5] = 32'h22220014;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkEnable = 1'b1;
      checkOutput("rst_owner", owner, 2'b00);
      checkOutput("rst_mem_en", mem_en, 1'b0);
      checkOutput("rst_bus_err", bus_err, 1'b0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Fetch only, ack in ISSUE
      $display("[TB] fetch only");
      ackDelay = 0;
      applyStimulus(1, 32'h4, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t1_c0_stall", stall, 1'b1);
      checkOutput("t1_c0_mem_en", mem_en, 1'b0);
      @(negedge clk);
      checkOutput("t1_c1_mem_en", mem_en, 1'b1);
      checkOutput("t1_c1_owner", owner, 2'b01);
      checkOutput("t1_c1_stall", stall, 1'b1);
      checkOutput("t1_c1_mem_addr", mem_addr, 32'h4);
      @(negedge clk);
      checkOutput("t1_c2_i_ready", i_ready, 1'b1);
      checkOutput("t1_c2_i_rdata", i_rdata, 32'h200A0005);
      checkOutput("t1_c2_owner", owner, 2'b01);
      checkOutput("t1_c2_stall", stall, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);

      // Store with ack two cycles after mem_en
      $display("[TB] store");
      ackDelay = 2;
      applyStimulus(0, 0, 1, 1, 32'h8, 32'h0C);
      @(negedge clk);
      checkOutput("t2_c0_mem_en", mem_en, 1'b0);
      @(negedge clk);
      checkOutput("t2_c1_mem_en", mem_en, 1'b1);
      checkOutput("t2_c1_mem_we", mem_we, 1'b1);
      checkOutput("t2_c1_mem_addr", mem_addr, 32'h8);
      checkOutput("t2_c1_mem_wdata", mem_wdata, 32'h0C);
      checkOutput("t2_c1_owner", owner, 2'b10);
      @(negedge clk);
      checkOutput("t2_c2_d_ready", d_ready, 1'b0);
      @(negedge clk);
      checkOutput("t2_c3_d_ready", d_ready, 1'b0);
      @(negedge clk);
      checkOutput("t2_c4_d_ready", d_ready, 1'b1);
      checkOutput("t2_c4_d_rdata", d_rdata, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      checkOutput("t2_stored_word", memArr[2], 32'h0C);

      // Contention with both requests held
      $display("[TB] contention");
      ackDelay = 0;
      dutGrants.delete();
      modelGrants.delete();
      applyStimulus(1, 32'h10, 1, 0, 32'h14, 0);
      nReady = 0;
      for (int k = 0; k < 60 && nReady < 8; k++) begin
         @(negedge clk);
         if (i_ready || d_ready) nReady++;
      end
      checkOutput("t3_ready_count", nReady, 8);
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      gs = "DDDFDDDF";
      checkOutput("t3_dut_grant_count", dutGrants.size(), 8);
      checkOutput("t3_model_grant_count", modelGrants.size(), 8);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("t3_dut_grant_%0d", k),
                     (k < dutGrants.size()) ? dutGrants[k] : 8'h3F, gs[k]);
         checkOutput($sformatf("t3_model_grant_%0d", k),
                     (k < modelGrants.size()) ? modelGrants[k] : 8'h3F, gs[k]);
      end

      // Timeout: memory never answers
      $display("[TB] timeout");
      ackDelay = -1;
      applyStimulus(0, 0, 1, 0, 32'h18, 0);
      @(negedge clk);
      early = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (d_ready) early = 1'b1;
      end
      checkOutput("t4_no_early_ready", early, 1'b0);
      checkOutput("t4_err_before_resp", bus_err, 1'b0);
      @(negedge clk);
      checkOutput("t4_c17_d_ready", d_ready, 1'b1);
      checkOutput("t4_c17_d_rdata", d_rdata, 32'h0);
      checkOutput("t4_c17_bus_err", bus_err, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      ackDelay = 0;
      applyStimulus(1, 32'h4, 0, 0, 0, 0);
      waitReady("t4b_ready_seen", 10, n);
      checkOutput("t4b_i_rdata", i_rdata, 32'h200A0005);
      checkOutput("t4b_err_sticky", bus_err, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);

      // Reset during WAIT followed by a stale ack
      $display("[TB] reset mid-wait");
      ackDelay = -1;
      applyStimulus(1, 32'h20, 0, 0, 0, 0);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      i_req = 1'b0;
      injectAck = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t5_rst_owner", owner, 2'b00);
      checkOutput("t5_rst_mem_en", mem_en, 1'b0);
      checkOutput("t5_rst_i_ready", i_ready, 1'b0);
      checkOutput("t5_rst_i_rdata", i_rdata, 32'h0);
      checkOutput("t5_rst_bus_err", bus_err, 1'b0);
      checkOutput("t5_rst_mem_addr", mem_addr, 32'h0);
      checkOutput("t5_rst_mem_wdata", mem_wdata, 32'h0);
      checkOutput("t5_rst_stall", stall, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      injectAck = 1'b0;
      early = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (i_ready || d_ready || owner != 2'b00) early = 1'b1;
      end
      checkOutput("t5_stale_ack_ignored", early, 1'b0);
      ackDelay = 0;
      applyStimulus(1, 32'h4, 0, 0, 0, 0);
      waitReady("t5_ready_seen", 10, n);
      checkOutput("t5_latency", n, 3);
      checkOutput("t5_i_rdata", i_rdata, 32'h200A0005);
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);

      // Back-to-back loads, address changed during the ready cycle
      $display("[TB] back-to-back loads");
      ackDelay = 0;
      applyStimulus(0, 0, 1, 0, 32'h0, 0);
      enBase = enCount;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t6_c1_mem_addr", mem_addr, 32'h0);
      applyStimulus(0, 0, 1, 0, 32'h4, 0);
      @(negedge clk);
      checkOutput("t6_c2_d_ready", d_ready, 1'b1);
      checkOutput("t6_c2_d_rdata", d_rdata, 32'h8C010000);
      @(negedge clk);
      checkOutput("t6_c3_d_ready", d_ready, 1'b0);
      @(negedge clk);
      checkOutput("t6_c4_mem_en", mem_en, 1'b1);
      checkOutput("t6_c4_mem_addr", mem_addr, 32'h4);
      @(negedge clk);
      checkOutput("t6_c5_d_ready", d_ready, 1'b1);
      checkOutput("t6_c5_d_rdata", d_rdata, 32'h200A0005);
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      checkOutput("t6_en_count", enCount - enBase, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
